// File: rtl/lsb.sv
// Load/store buffer: in-order circular queue that snoops both CDBs, executes memory ops
// strictly at the head (one request in flight) and reports results on the LSB broadcast bus.
`ifndef OPERATOR_WIDTH
`define OPERATOR_WIDTH 4
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module lsb #(
  parameter int          LSB_SIZE = 16,
  parameter logic [31:0] IO_BASE  = 32'h00030000
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_rdy,
  input  logic                       in_flush,
  output logic                       out_capacity_full,
  input  logic                       in_decoder_assign_enable,
  input  logic [`OPERATOR_WIDTH-1:0] in_decoder_type,
  input  logic [`ROB_WIDTH-1:0]      in_decoder_reorder,
  input  logic [31:0]                in_decoder_imm,
  input  logic                       in_decoder_rs_ready,
  input  logic                       in_decoder_rt_ready,
  input  logic [31:0]                in_decoder_rs_value,
  input  logic [31:0]                in_decoder_rt_value,
  input  logic [`ROB_WIDTH-1:0]      in_decoder_rs_reorder,
  input  logic [`ROB_WIDTH-1:0]      in_decoder_rt_reorder,
  input  logic                       in_alu_broadcast_enable,
  input  logic [`ROB_WIDTH-1:0]      in_alu_broadcast_reorder,
  input  logic [31:0]                in_alu_broadcast_result,
  input  logic [`ROB_WIDTH-1:0]      in_rob_head_reorder,
  input  logic                       in_rob_store_enable,
  output logic                       out_rob_store_over,
  output logic                       out_broadcast_enable,
  output logic [`ROB_WIDTH-1:0]      out_broadcast_reorder,
  output logic [31:0]                out_broadcast_result,
  output logic                       out_broadcast_io_read,
  output logic                       out_mem_enable,
  output logic                       out_mem_wr,
  output logic [31:0]                out_mem_addr,
  output logic [31:0]                out_mem_data,
  output logic [2:0]                 out_mem_size,
  input  logic                       in_mem_done,
  input  logic [31:0]                in_mem_data,
  output logic [1:0]                 out_dbg_state,
  output logic [$clog2(LSB_SIZE):0]  out_dbg_count
);
  localparam int IW = $clog2(LSB_SIZE);
  localparam logic [IW:0] FULL_CNT = (IW+1)'(LSB_SIZE);
  localparam logic [`OPERATOR_WIDTH-1:0] OP_LB = 0, OP_LH = 1, OP_LW = 2, OP_LBU = 3,
                                         OP_LHU = 4, OP_SB = 5, OP_SH = 6, OP_SW = 7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DRAIN = 2'd2} state_t;
  state_t r_state;

  logic                       r_valid    [LSB_SIZE];
  logic [`OPERATOR_WIDTH-1:0] r_type     [LSB_SIZE];
  logic [`ROB_WIDTH-1:0]      r_reorder  [LSB_SIZE];
  logic [31:0]                r_imm      [LSB_SIZE];
  logic                       r_rs_ready [LSB_SIZE];
  logic                       r_rt_ready [LSB_SIZE];
  logic [31:0]                r_rs_val   [LSB_SIZE];
  logic [31:0]                r_rt_val   [LSB_SIZE];
  logic [`ROB_WIDTH-1:0]      r_rs_tag   [LSB_SIZE];
  logic [`ROB_WIDTH-1:0]      r_rt_tag   [LSB_SIZE];

  logic [IW-1:0] r_head, r_tail;
  logic [IW:0]   r_count;

  // Details of the single in-flight request.
  logic                       r_cur_store, r_cur_io, r_cur_flushed;
  logic [`OPERATOR_WIDTH-1:0] r_cur_type;
  logic [`ROB_WIDTH-1:0]      r_cur_reorder;
  logic [31:0]                r_cur_rt;

  function automatic logic cdb_hit(input logic [`ROB_WIDTH-1:0] tag);
    return (in_alu_broadcast_enable && in_alu_broadcast_reorder == tag) ||
           (out_broadcast_enable && out_broadcast_reorder == tag);
  endfunction

  function automatic logic [31:0] cdb_val(input logic [`ROB_WIDTH-1:0] tag);
    return (in_alu_broadcast_enable && in_alu_broadcast_reorder == tag) ?
           in_alu_broadcast_result : out_broadcast_result;
  endfunction

  logic        w_full, w_assign, w_retire, w_issue;
  logic        w_h_ops, w_h_store, w_h_io, w_h_owner;
  logic [31:0] w_addr, w_load_val;
  logic [2:0]  w_size;

  assign w_full    = (r_count == FULL_CNT);
  assign w_assign  = in_decoder_assign_enable && !w_full && !in_flush;
  assign w_retire  = (r_state == S_BUSY) && in_mem_done && !in_flush && !r_cur_flushed;
  assign w_addr    = r_rs_val[r_head] + r_imm[r_head];
  assign w_h_store = (r_type[r_head] >= OP_SB);
  assign w_h_io    = (w_addr >= IO_BASE);
  assign w_h_owner = (in_rob_head_reorder == r_reorder[r_head]);
  assign w_h_ops   = r_valid[r_head] && r_rs_ready[r_head] && r_rt_ready[r_head];
  assign w_issue   = w_h_ops && (w_h_store ? (in_rob_store_enable && w_h_owner)
                                           : (!w_h_io || w_h_owner));

  always_comb begin
    w_size = 3'd4;
    if (r_type[r_head] == OP_LB || r_type[r_head] == OP_LBU || r_type[r_head] == OP_SB)
      w_size = 3'd1;
    else if (r_type[r_head] == OP_LH || r_type[r_head] == OP_LHU || r_type[r_head] == OP_SH)
      w_size = 3'd2;
  end

  always_comb begin
    w_load_val = in_mem_data;
    case (r_cur_type)
      OP_LB:   w_load_val = {{24{in_mem_data[7]}}, in_mem_data[7:0]};
      OP_LH:   w_load_val = {{16{in_mem_data[15]}}, in_mem_data[15:0]};
      OP_LBU:  w_load_val = {24'd0, in_mem_data[7:0]};
      OP_LHU:  w_load_val = {16'd0, in_mem_data[15:0]};
      default: w_load_val = in_mem_data;
    endcase
  end

  assign out_capacity_full = w_full;
  assign out_dbg_state     = r_state;
  assign out_dbg_count     = r_count;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
      r_head <= '0; r_tail <= '0; r_count <= '0;
      r_cur_store <= 1'b0; r_cur_io <= 1'b0; r_cur_flushed <= 1'b0;
      r_cur_type <= '0; r_cur_reorder <= '0; r_cur_rt <= '0;
      out_rob_store_over <= 1'b0;
      out_broadcast_enable <= 1'b0; out_broadcast_reorder <= '0;
      out_broadcast_result <= '0; out_broadcast_io_read <= 1'b0;
      out_mem_enable <= 1'b0; out_mem_wr <= 1'b0; out_mem_addr <= '0;
      out_mem_data <= '0; out_mem_size <= '0;
      for (int i = 0; i < LSB_SIZE; i++) begin
        r_valid[i] <= 1'b0; r_type[i] <= '0; r_reorder[i] <= '0; r_imm[i] <= '0;
        r_rs_ready[i] <= 1'b0; r_rt_ready[i] <= 1'b0; r_rs_val[i] <= '0;
        r_rt_val[i] <= '0; r_rs_tag[i] <= '0; r_rt_tag[i] <= '0;
      end
    end else if (in_rdy) begin
      out_broadcast_enable <= 1'b0;
      out_broadcast_io_read <= 1'b0;
      out_rob_store_over <= 1'b0;

      for (int i = 0; i < LSB_SIZE; i++) begin
        if (r_valid[i] && !r_rs_ready[i] && cdb_hit(r_rs_tag[i])) begin
          r_rs_ready[i] <= 1'b1; r_rs_val[i] <= cdb_val(r_rs_tag[i]);
        end
        if (r_valid[i] && !r_rt_ready[i] && cdb_hit(r_rt_tag[i])) begin
          r_rt_ready[i] <= 1'b1; r_rt_val[i] <= cdb_val(r_rt_tag[i]);
        end
      end

      if (w_assign) begin
        r_valid[r_tail]   <= 1'b1;
        r_type[r_tail]    <= in_decoder_type;
        r_reorder[r_tail] <= in_decoder_reorder;
        r_imm[r_tail]     <= in_decoder_imm;
        r_rs_tag[r_tail]  <= in_decoder_rs_reorder;
        r_rt_tag[r_tail]  <= in_decoder_rt_reorder;
        r_rs_ready[r_tail] <= in_decoder_rs_ready || cdb_hit(in_decoder_rs_reorder);
        r_rt_ready[r_tail] <= in_decoder_rt_ready || cdb_hit(in_decoder_rt_reorder);
        r_rs_val[r_tail] <= in_decoder_rs_ready ? in_decoder_rs_value : cdb_val(in_decoder_rs_reorder);
        r_rt_val[r_tail] <= in_decoder_rt_ready ? in_decoder_rt_value : cdb_val(in_decoder_rt_reorder);
        r_tail <= r_tail + 1'b1;
      end

      case (r_state)
        S_IDLE: if (w_issue && !in_flush) begin
          out_mem_enable <= 1'b1;
          out_mem_wr     <= w_h_store;
          out_mem_addr   <= w_addr;
          out_mem_data   <= r_rt_val[r_head];
          out_mem_size   <= w_size;
          r_cur_store    <= w_h_store;
          r_cur_io       <= w_h_io;
          r_cur_type     <= r_type[r_head];
          r_cur_reorder  <= r_reorder[r_head];
          r_cur_rt       <= r_rt_val[r_head];
          r_cur_flushed  <= 1'b0;
          r_state        <= S_BUSY;
        end
        S_BUSY: begin
          if (in_mem_done) begin
            out_mem_enable <= 1'b0;
            r_state <= S_IDLE;
            if (r_cur_store) out_rob_store_over <= 1'b1;
            if (!in_flush && !r_cur_flushed) begin
              out_broadcast_enable  <= 1'b1;
              out_broadcast_reorder <= r_cur_reorder;
              out_broadcast_result  <= r_cur_store ? r_cur_rt : w_load_val;
              out_broadcast_io_read <= !r_cur_store && r_cur_io;
            end
          end else if (in_flush) begin
            // A committed store must still reach memory; only loads are abandoned.
            if (r_cur_store) r_cur_flushed <= 1'b1;
            else             r_state <= S_DRAIN;
          end
        end
        S_DRAIN: if (in_mem_done) begin
          out_mem_enable <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head <= r_head + 1'b1;
      end

      if (in_flush) begin
        for (int i = 0; i < LSB_SIZE; i++) r_valid[i] <= 1'b0;
        r_head  <= r_tail;
        r_count <= '0;
      end else begin
        r_count <= r_count + (IW+1)'(w_assign) - (IW+1)'(w_retire);
      end
    end
  end
endmodule
